// File: rtl/fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_reader_pkg
// Shared definitions for the FIFO read-side controller:
//   - state_t       : controller FSM states
//   - DEF_DW        : default data width (matches FIFO din/dout)
//   - DEF_BUF_DEPTH : default output buffer depth (power of 2, >= 2)
//   - DEF_LEN_W     : default burst length / remaining counter width
// -----------------------------------------------------------------------------
package fifo_reader_pkg;

    localparam int DEF_DW        = 8;
    localparam int DEF_BUF_DEPTH = 2;
    localparam int DEF_LEN_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_reader_buf.sv
// -----------------------------------------------------------------------------
// fifo_reader_buf
// DEPTH-entry circular buffer that absorbs the FIFO's registered read latency.
// Pointers wrap modulo DEPTH (DEPTH must be a power of 2).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_data at the tail (caller guarantees not full)
//   push_data   : data to write
//   pop         : drop the head entry (caller guarantees not empty)
//   head_data   : current head entry (meaningful only when count != 0)
//   count       : number of occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_reader_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; stale contents are
    // unreachable because count gates every read of the head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
// Read-side controller for a synchronous FIFO with one cycle of registered read
// latency. On start it drains len words and forwards them on a valid/ready
// stream, pulsing done once the last word has been accepted downstream.
// Optional assertions are compiled in when FIFO_READER_SVA_EN is defined.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start, len  : one-cycle burst request and word count (sampled in IDLE)
//   busy        : burst in progress (any state other than IDLE)
//   done        : one-cycle pulse when the burst is fully delivered
//   fifo_empty  : FIFO empty flag
//   fifo_rd     : FIFO read strobe
//   fifo_dout   : FIFO read data, valid one cycle after a read
//   m_valid, m_ready, m_data : downstream stream
// -----------------------------------------------------------------------------
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [DW-1:0]    fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int FW = CW + 1;
    localparam logic [FW-1:0] DEPTH_F = FW'(BUF_DEPTH);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  remaining_q;
    logic              inflight_q;
    logic [CW-1:0]     occupancy;
    logic [DW-1:0]     head_data;
    logic [FW-1:0]     fill;
    logic              pop;

    // Entries committed to the buffer: stored words plus the one still in the
    // FIFO's output register. Reads are only issued when this has headroom.
    assign fill = {1'b0, occupancy} + {{CW{1'b0}}, inflight_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd;
            if (state_q == IDLE && start && len != '0)
                remaining_q <= len;
            else if (fifo_rd)
                remaining_q <= remaining_q - LEN_W'(1);
        end
    end

    // NOTE: every output of this block is given a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        fifo_rd = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len != '0) ? READ : DONE;
            end
            READ: begin
                fifo_rd = !fifo_empty && (remaining_q != '0) && (fill < DEPTH_F);
                if (remaining_q == '0 || (fifo_rd && remaining_q == LEN_W'(1)))
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (!inflight_q && occupancy == '0) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign m_valid = (occupancy != '0);
    // Forcing zero when empty keeps m_data clean out of reset without having
    // to clear the buffer storage.
    assign m_data  = m_valid ? head_data : '0;
    assign pop     = m_valid && m_ready;

    // Data read in cycle N is on fifo_dout in cycle N+1, exactly when the
    // in-flight flag is set, so the flag doubles as the push strobe. Reset
    // clears the flag, which discards any word still in the FIFO's register.
    fifo_reader_buf #(
        .DW    (DW),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_dout),
        .pop       (pop),
        .head_data (head_data),
        .count     (occupancy)
    );

`ifdef FIFO_READER_SVA_EN
    logic [LEN_W-1:0] sva_len_q;
    logic [LEN_W-1:0] sva_words_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sva_len_q   <= '0;
            sva_words_q <= '0;
        end else if (state_q == IDLE && start) begin
            sva_len_q   <= len;
            sva_words_q <= '0;
        end else if (pop) begin
            sva_words_q <= sva_words_q + LEN_W'(1);
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        fifo_rd |-> !fifo_empty);
    a_stream_hold: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        done |=> !done);
    a_occupancy: assert property (@(posedge clk) disable iff (rst)
        occupancy <= CW'(BUF_DEPTH));
    a_word_count: assert property (@(posedge clk) disable iff (rst)
        done |-> (sva_words_q == sva_len_q));
`endif

endmodule
